// File: rtl/mips_pkg.sv
// Shared widths, constants and helpers for the MIPS front end.
// Imported by the fetch interface, the fetch stage and its checker.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  PC_INC           = 32'h0000_0004;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] pc_align(input logic [ADDR_W-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's memory, redirect and decoder-side handshakes.
// The master side is the fetch stage; the slave side is memory plus decoder.
interface instruction_fetch_if;
    import mips_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous flush; the head word is read
// combinationally. Callers never pop when empty nor push when full.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
        end
    end

    // Storage needs no reset: nothing is visible until the count says so.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/fetch_fifo_chk.sv
// Invariants of the fetch stage: the prefetch buffer never overflows and
// memory never answers a read that was not issued.
module fetch_fifo_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             i_push,
    input logic             i_pop,
    input logic             i_full,
    input logic             i_rsp,
    input logic [CNT_W-1:0] i_outstanding
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && i_full && !i_pop));

    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        i_outstanding <= CNT_W'(DEPTH));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        i_rsp |-> (i_outstanding != '0));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps at most FIFO_DEPTH reads plus buffered words
// in flight, and discards responses made stale by a redirect.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int                FIFO_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic               r_started;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   w_outstanding_next;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   w_drop_cnt_next;
    logic [ADDR_W-1:0]  r_inflight_pc [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_if_wr_ptr;
    logic [PTR_W-1:0]   r_if_rd_ptr;
    logic               w_req_valid;
    logic               w_req_hs;
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W:0]     w_occupancy;
    logic [ENTRY_W-1:0] w_head;
    logic               w_empty;
    logic               w_full;
    logic [CNT_W-1:0]   w_count;

    // Stale reads still occupy a slot, which bounds the in-flight PC queue too.
    assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_req_valid = r_started && (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign w_req_hs    = w_req_valid && bus.imem_req_ready;
    assign w_rsp       = bus.imem_rsp_valid;
    assign w_push      = w_rsp && !w_drop && !bus.redirect_valid;
    assign w_pop       = !w_empty && bus.instr_ready;

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.instr_valid    = !w_empty;
    assign bus.instr          = w_empty ? MIPS_NOP : w_head[ENTRY_W-1:ADDR_W];
    assign bus.instr_pc       = w_empty ? '0 : w_head[ADDR_W-1:0];

    always_comb begin
        w_drop             = 1'b0;
        w_outstanding_next = r_outstanding + CNT_W'(w_req_hs) - CNT_W'(w_rsp);
        case (r_state)
            ST_RUN:   w_drop = 1'b0;
            ST_DRAIN: w_drop = 1'b1;
            default:  w_drop = 1'b0;
        endcase
        // A redirect marks everything still in flight after this cycle as stale.
        if (bus.redirect_valid) begin
            w_drop_cnt_next = w_outstanding_next;
        end else if (w_drop && w_rsp) begin
            w_drop_cnt_next = r_drop_cnt - CNT_W'(1);
        end else begin
            w_drop_cnt_next = r_drop_cnt;
        end
        if (w_drop_cnt_next != '0) begin
            w_state_next = ST_DRAIN;
        end else begin
            w_state_next = ST_RUN;
        end
        if (bus.redirect_valid) begin
            w_pc_next = pc_align(bus.redirect_pc);
        end else if (w_req_hs) begin
            w_pc_next = r_pc + PC_INC;
        end else begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_started     <= 1'b0;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_if_wr_ptr   <= '0;
            r_if_rd_ptr   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_started     <= 1'b1;
            r_pc          <= w_pc_next;
            r_outstanding <= w_outstanding_next;
            r_drop_cnt    <= w_drop_cnt_next;
            if (w_req_hs) r_if_wr_ptr <= r_if_wr_ptr + PTR_W'(1);
            if (w_rsp)    r_if_rd_ptr <= r_if_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_hs) r_inflight_pc[r_if_wr_ptr] <= r_pc;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_wdata ({bus.imem_rsp_data, r_inflight_pc[r_if_rd_ptr]}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    fetch_fifo_chk #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_push        (w_push),
        .i_pop         (w_pop),
        .i_full        (w_full),
        .i_rsp         (w_rsp),
        .i_outstanding (r_outstanding)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a bench-side memory answers accepted
// reads in order, and each scenario compares the fetched stream to hand-derived values.
module tb_instruction_fetch;
    import mips_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetch_if ifc();

    instruction_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    bit          mem_en;
    logic [31:0] mem_q[$];
    logic [31:0] issued[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    bit          vld_hist[$];
    bit          req_hist[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic clear_logs();
        issued.delete(); got_pc.delete(); got_instr.delete();
        vld_hist.delete(); req_hist.delete();
    endtask

    // One clock: log what happens at the coming edge, then present the next memory response.
    task automatic tick();
        vld_hist.push_back(ifc.instr_valid);
        req_hist.push_back(ifc.imem_req_valid);
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
            mem_q.push_back(ifc.imem_addr);
            issued.push_back(ifc.imem_addr);
        end
        if (ifc.instr_valid && ifc.instr_ready) begin
            got_pc.push_back(ifc.instr_pc);
            got_instr.push_back(ifc.instr);
        end
        @(posedge clk);
        @(negedge clk);
        ifc.redirect_valid = 1'b0;
        if (mem_en && mem_q.size() > 0) begin
            ifc.imem_rsp_valid = 1'b1;
            ifc.imem_rsp_data  = mem_word(mem_q.pop_front());
        end else begin
            ifc.imem_rsp_valid = 1'b0;
            ifc.imem_rsp_data  = 32'h0000_0000;
        end
    endtask

    task automatic drive_idle();
        ifc.imem_req_ready = 1'b1;
        ifc.imem_rsp_valid = 1'b0;
        ifc.imem_rsp_data  = 32'h0000_0000;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc    = 32'h0000_0000;
        ifc.instr_ready    = 1'b1;
        mem_en = 1'b1;
        mem_q.delete();
        clear_logs();
    endtask

    // Leaves the bench at the negedge of the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_stream(input string name, input logic [31:0] base, input int n);
        n_cmp++;
        if (got_pc.size() !== n) begin
            n_err++;
            $display("FAIL %s_count: got %0d instrs, expected %0d", name, got_pc.size(), n);
        end
        for (int i = 0; i < got_pc.size() && i < n; i++) begin
            logic [31:0] e;
            e = base + 32'(4 * i);
            n_cmp++;
            if (got_pc[i] !== e || got_instr[i] !== mem_word(e)) begin
                n_err++;
                $display("FAIL %s[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h",
                         name, i, got_pc[i], got_instr[i], e, mem_word(e));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        n_cmp++;
        if (ifc.imem_req_valid !== 1'b0 || ifc.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valids: got req=%b instr_valid=%b, expected 0/0",
                     ifc.imem_req_valid, ifc.instr_valid);
        end
        n_cmp++;
        if (ifc.imem_addr !== RST_PC || ifc.instr !== 32'h0 || ifc.instr_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_values: got addr=%h instr=%h pc=%h, expected %h/0/0",
                     ifc.imem_addr, ifc.instr, ifc.instr_pc, RST_PC);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ifc.imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release_req: got %b, expected 0 before first edge", ifc.imem_req_valid);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL first_req: got valid=%b addr=%h, expected 1/%h",
                     ifc.imem_req_valid, ifc.imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        repeat (10) tick();
        n_cmp++;
        if (issued.size() !== 10) begin
            n_err++;
            $display("FAIL stream_issue_count: got %0d, expected 10", issued.size());
        end
        for (int i = 0; i < issued.size(); i++) begin
            n_cmp++;
            if (issued[i] !== 32'(4 * i) || req_hist[i] !== 1'b1) begin
                n_err++;
                $display("FAIL stream_issue[%0d]: got addr=%h valid=%b, expected %h/1",
                         i, issued[i], req_hist[i], 32'(4 * i));
            end
        end
        n_cmp++;
        if (vld_hist[0] !== 1'b0 || vld_hist[1] !== 1'b0 || vld_hist[2] !== 1'b1) begin
            n_err++;
            $display("FAIL stream_latency: got instr_valid %b%b%b, expected 001",
                     vld_hist[0], vld_hist[1], vld_hist[2]);
        end
        check_stream("stream", 32'h0000_0000, 8);
    endtask

    task automatic test_backpressure();
        do_reset();
        ifc.instr_ready = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (issued.size() !== DEPTH || ifc.imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_issue_limit: got %0d reads, req_valid=%b, expected %0d/0",
                     issued.size(), ifc.imem_req_valid, DEPTH);
        end
        n_cmp++;
        if (ifc.instr_valid !== 1'b1 || ifc.instr_pc !== 32'h0 || got_pc.size() !== 0) begin
            n_err++;
            $display("FAIL bp_hold: got valid=%b pc=%h pops=%0d, expected 1/0/0",
                     ifc.instr_valid, ifc.instr_pc, got_pc.size());
        end
        ifc.instr_ready = 1'b1;
        repeat (12) tick();
        check_stream("bp_resume", 32'h0000_0000, 12);
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        mem_en = 1'b0;
        repeat (2) tick();
        ifc.imem_req_ready = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0000_1003;
        mem_en = 1'b1;
        tick();
        ifc.imem_req_ready = 1'b1;
        n_cmp++;
        if (ifc.imem_addr !== 32'h0000_1000 || ifc.instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_target: got addr=%h instr_valid=%b, expected 00001000/0",
                     ifc.imem_addr, ifc.instr_valid);
        end
        clear_logs();
        repeat (8) tick();
        n_cmp++;
        if (vld_hist[0] !== 1'b0 || vld_hist[1] !== 1'b0 || vld_hist[2] !== 1'b0 || vld_hist[3] !== 1'b1) begin
            n_err++;
            $display("FAIL rd_no_stale: got instr_valid %b%b%b%b, expected 0001",
                     vld_hist[0], vld_hist[1], vld_hist[2], vld_hist[3]);
        end
        check_stream("rd_inflight", 32'h0000_1000, 5);
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        tick();
        n_cmp++;
        if (ifc.imem_req_valid !== 1'b1 || ifc.imem_addr !== 32'h0000_0004) begin
            n_err++;
            $display("FAIL rs_setup: got req=%b addr=%h, expected 1/00000004",
                     ifc.imem_req_valid, ifc.imem_addr);
        end
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'h0000_2000;
        tick();
        clear_logs();
        repeat (6) tick();
        n_cmp++;
        if (issued.size() < 1 || issued[0] !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL rs_first_issue: got %0d reads, first=%h, expected 00002000",
                     issued.size(), (issued.size() > 0) ? issued[0] : 32'hxxxx_xxxx);
        end
        n_cmp++;
        if (vld_hist[0] !== 1'b0 || vld_hist[1] !== 1'b0 || vld_hist[2] !== 1'b1) begin
            n_err++;
            $display("FAIL rs_no_stale: got instr_valid %b%b%b, expected 001",
                     vld_hist[0], vld_hist[1], vld_hist[2]);
        end
        check_stream("rs_same_cycle", 32'h0000_2000, 4);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = 32'hFFFF_FFF8;
        tick();
        clear_logs();
        repeat (6) tick();
        n_cmp++;
        if (got_pc.size() !== 4) begin
            n_err++;
            $display("FAIL wrap_count: got %0d instrs, expected 4", got_pc.size());
        end
        for (int i = 0; i < got_pc.size() && i < 4; i++) begin
            logic [31:0] e;
            e = 32'hFFFF_FFF8 + 32'(4 * i);
            n_cmp++;
            if (got_pc[i] !== e || got_instr[i] !== mem_word(e)) begin
                n_err++;
                $display("FAIL wrap[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h",
                         i, got_pc[i], got_instr[i], e, mem_word(e));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (6) tick();
        n_cmp++;
        if (ifc.instr_valid !== 1'b1 || ifc.imem_req_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ar_pre: got instr_valid=%b req=%b, expected 1/1",
                     ifc.instr_valid, ifc.imem_req_valid);
        end
        #2;
        rst_n = 1'b0;
        ifc.imem_rsp_valid = 1'b0;
        mem_q.delete();
        #1;
        n_cmp++;
        if (ifc.instr_valid !== 1'b0 || ifc.imem_req_valid !== 1'b0 || ifc.imem_addr !== RST_PC) begin
            n_err++;
            $display("FAIL ar_immediate: got instr_valid=%b req=%b addr=%h, expected 0/0/%h",
                     ifc.instr_valid, ifc.imem_req_valid, ifc.imem_addr, RST_PC);
        end
        @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (5) tick();
        n_cmp++;
        if (issued.size() !== 5 || issued[0] !== RST_PC) begin
            n_err++;
            $display("FAIL ar_restart: got %0d reads, first=%h, expected 5 from %h",
                     issued.size(), (issued.size() > 0) ? issued[0] : 32'hxxxx_xxxx, RST_PC);
        end
        check_stream("ar_stream", RST_PC, 3);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_pc_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
